// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with registered read data,
// occupancy output, programmable almost-full/almost-empty thresholds and
// sticky overflow/underflow flags. Synchronous active-high reset.
module sync_fifo_param #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr,
    input  logic [DATA_W-1:0]          din,
    input  logic                       rd,
    input  logic                       clr_err,
    output logic [DATA_W-1:0]          dout,
    output logic                       dout_valid,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full,
    output logic                       almost_empty,
    output logic                       almost_full,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_THRESH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  w_ptr;
    logic [PTR_W-1:0]  r_ptr;
    logic              wr_acc;
    logic              rd_acc;
    logic [CNT_W-1:0]  count_nxt;

    // Acceptance and next occupancy, decided from the pre-edge flags.
    always_comb begin
        // NOTE: every combinational output gets a value on every path, so no latch is inferred.
        wr_acc    = wr && !full;
        rd_acc    = rd && !empty;
        count_nxt = count + CNT_W'(wr_acc) - CNT_W'(rd_acc);
    end

    // Status flags decode straight from the registered count.
    always_comb begin
        empty        = (count == '0);
        full         = (count == DEPTH_C);
        almost_empty = (count <= AE_C);
        almost_full  = (count >= AF_C);
    end

    // Storage array: written on an accepted write, never reset.
    always_ff @(posedge clk) begin
        // NOTE: the data array has no reset; stale contents are unreachable because the pointers and count are reset.
        if (wr_acc) begin
            mem[w_ptr] <= din;
        end
    end

    // Pointers, occupancy and registered read port.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_ptr      <= '0;
            r_ptr      <= '0;
            count      <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            count      <= count_nxt;
            dout_valid <= rd_acc;
            if (wr_acc) begin
                w_ptr <= w_ptr + PTR_W'(1);
            end
            if (rd_acc) begin
                r_ptr <= r_ptr + PTR_W'(1);
                dout  <= mem[r_ptr];
            end
        end
    end

    // Sticky error flags; a new error event beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr && full) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (rd && empty) begin
                underflow <= 1'b1;
            end else if (clr_err) begin
                underflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param (DEPTH=16, DATA_W=8, default
// thresholds). A table of directed vectors is built first, then each vector
// is driven on the falling edge and checked just after the next rising edge.
module tb_sync_fifo_param;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;

    typedef struct {
        logic       rst;
        logic       wr;
        logic       rd;
        logic       clr;
        logic [7:0] din;
        int         cnt;
        logic [3:0] flags;   // {empty, full, almost_empty, almost_full}
        logic       dv;
        logic [7:0] dout;
        logic       ovf;
        logic       unf;
    } vec_t;

    logic              clk;
    logic              rst;
    logic              wr;
    logic [DATA_W-1:0] din;
    logic              rd;
    logic              clr_err;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic [4:0]        count;
    logic              empty;
    logic              full;
    logic              almost_empty;
    logic              almost_full;
    logic              overflow;
    logic              underflow;

    int total = 0;
    int bad   = 0;
    vec_t vecs[$];

    sync_fifo_param #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr          (wr),
        .din         (din),
        .rd          (rd),
        .clr_err     (clr_err),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .count       (count),
        .empty       (empty),
        .full        (full),
        .almost_empty(almost_empty),
        .almost_full (almost_full),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int idx, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s vec=%0d got=0x%0h expected=0x%0h", name, idx, act, exp);
        end
    endtask

    // Append one vector; flags come from the expected count and the
    // thresholds AF=14, AE=2.
    function automatic void push(input logic r, input logic w, input logic rq,
                                 input logic c, input logic [7:0] d,
                                 input int cnt, input logic dv, input logic [7:0] q,
                                 input logic ovf, input logic unf);
        vec_t v;
        v.rst   = r;
        v.wr    = w;
        v.rd    = rq;
        v.clr   = c;
        v.din   = d;
        v.cnt   = cnt;
        v.flags = {cnt == 0, cnt == 16, cnt <= 2, cnt >= 14};
        v.dv    = dv;
        v.dout  = q;
        v.ovf   = ovf;
        v.unf   = unf;
        vecs.push_back(v);
    endfunction

    initial begin
        rst = 1'b1; wr = 1'b0; rd = 1'b0; clr_err = 1'b0; din = '0;

        // Reset state.
        push(1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0);
        // Fill with 0x00..0x0F.
        for (int i = 0; i < 16; i++)
            push(0, 1, 0, 0, 8'(i), i + 1, 0, 8'h00, 0, 0);
        // Write while full together with clr_err: data dropped, overflow wins.
        push(0, 1, 0, 1, 8'hAA, 16, 0, 8'h00, 1, 0);
        push(0, 0, 0, 0, 8'h00, 16, 0, 8'h00, 1, 0);
        push(0, 0, 0, 1, 8'h00, 16, 0, 8'h00, 0, 0);
        // Drain in order.
        for (int k = 0; k < 16; k++)
            push(0, 0, 1, 0, 8'h00, 15 - k, 1, 8'(k), 0, 0);
        // Read while empty: underflow, dout holds, no strobe.
        push(0, 0, 1, 0, 8'h00, 0, 0, 8'h0F, 0, 1);
        push(0, 0, 0, 1, 8'h00, 0, 0, 8'h0F, 0, 0);
        // Mid-occupancy streaming across pointer wrap.
        for (int i = 0; i < 5; i++)
            push(0, 1, 0, 0, 8'(8'h20 + i), i + 1, 0, 8'h0F, 0, 0);
        for (int j = 0; j < 20; j++)
            push(0, 1, 1, 0, 8'(8'h25 + j), 5, 1, 8'(8'h20 + j), 0, 0);
        for (int k = 0; k < 5; k++)
            push(0, 0, 1, 0, 8'h00, 4 - k, 1, 8'(8'h34 + k), 0, 0);
        // rd+wr while empty: only the write lands.
        push(0, 1, 1, 0, 8'h55, 1, 0, 8'h38, 0, 1);
        push(0, 0, 0, 1, 8'h00, 1, 0, 8'h38, 0, 0);
        push(0, 0, 1, 0, 8'h00, 0, 1, 8'h55, 0, 0);
        // Fill, then rd+wr while full: only the read lands.
        for (int i = 0; i < 16; i++)
            push(0, 1, 0, 0, 8'(8'h60 + i), i + 1, 0, 8'h55, 0, 0);
        push(0, 1, 1, 0, 8'hEE, 15, 1, 8'h60, 1, 0);
        // Partial drain down to 7 entries with overflow still set.
        for (int k = 0; k < 8; k++)
            push(0, 0, 1, 0, 8'h00, 14 - k, 1, 8'(8'h61 + k), 1, 0);
        // Reset in the middle of traffic beats wr/rd.
        push(1, 1, 1, 0, 8'h77, 0, 0, 8'h00, 0, 0);
        push(0, 1, 0, 0, 8'h99, 1, 0, 8'h00, 0, 0);
        push(0, 0, 1, 0, 8'h00, 0, 1, 8'h99, 0, 0);

        foreach (vecs[n]) begin
            @(negedge clk);
            rst     = vecs[n].rst;
            wr      = vecs[n].wr;
            rd      = vecs[n].rd;
            clr_err = vecs[n].clr;
            din     = vecs[n].din;
            @(posedge clk);
            #1;
            check("count", n, int'(count), vecs[n].cnt);
            check("flags", n, int'({empty, full, almost_empty, almost_full}), int'(vecs[n].flags));
            check("dout_valid", n, int'(dout_valid), int'(vecs[n].dv));
            check("dout", n, int'(dout), int'(vecs[n].dout));
            check("overflow", n, int'(overflow), int'(vecs[n].ovf));
            check("underflow", n, int'(underflow), int'(vecs[n].unf));
        end

        @(negedge clk);
        rst = 1'b0; wr = 1'b0; rd = 1'b0; clr_err = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
